// File: rtl/kp_pkg.sv
// Shared widths, state encoding and token format for the keypoint reader.
package kp_pkg;

    localparam int ADDR_W     = 11;
    localparam int ROW_W      = 9;
    localparam int COL_W      = 10;
    localparam int WORD_W     = ROW_W + COL_W;
    localparam int CNT_W      = ADDR_W + 1;
    localparam int KP_MAX     = 2048;
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ_1,
        READ_2,
        DRAIN
    } state_t;

    typedef struct packed {
        logic             layer;
        logic             last;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } kp_t;

    // A count larger than the SRAM can hold reads the whole SRAM once.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count);
        return (count > CNT_W'(KP_MAX)) ? CNT_W'(KP_MAX) : count;
    endfunction

    // Split an SRAM word into row/column and attach the stream tags.
    function automatic kp_t make_kp(input logic layer, input logic last,
                                    input logic [WORD_W-1:0] word);
        kp_t kp;
        kp.layer = layer;
        kp.last  = last;
        kp.row   = word[WORD_W-1:COL_W];
        kp.col   = word[COL_W-1:0];
        return kp;
    endfunction

endpackage

// File: rtl/kp_skid_fifo.sv
// Small synchronous FIFO of keypoint tokens that absorbs the SRAM read latency.
// Pointer wrap relies on FIFO_DEPTH being a power of two.
module kp_skid_fifo
    import kp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  kp_t                   i_data,
    input  logic                  i_pop,
    output kp_t                   o_head,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic                  o_empty,
    output logic                  o_full
);

    kp_t                   r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write; entries are cleared on reset so the head reads as zero when idle.
    // NOTE: this memory is only two entries, so resetting it is cheap and keeps the outputs clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                // NOTE: sequential state always uses non-blocking assignment to avoid race-order bugs.
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keypoint_reader.sv
// Streams keypoints from SRAM 1 then SRAM 2 over valid/ready, one per cycle
// when unstalled. Reads are issued only when the skid FIFO is guaranteed room,
// counting the read still in flight through the SRAM.
module keypoint_reader
    import kp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  count_1,
    input  logic [CNT_W-1:0]  count_2,
    output logic [ADDR_W-1:0] keypoint_1_addr,
    input  logic [WORD_W-1:0] keypoint_1_dout,
    output logic [ADDR_W-1:0] keypoint_2_addr,
    input  logic [WORD_W-1:0] keypoint_2_dout,
    output logic              kp_valid,
    input  logic              kp_ready,
    output logic [ROW_W-1:0]  kp_row,
    output logic [COL_W-1:0]  kp_col,
    output logic              kp_layer,
    output logic              kp_last,
    output logic              busy,
    output logic              done
);

    localparam int PEND_W = FIFO_CNT_W + 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_count_1;
    logic [CNT_W-1:0]    r_count_2;
    logic [ADDR_W-1:0]   r_addr_1;
    logic [ADDR_W-1:0]   r_addr_2;
    logic                r_inflight;
    logic                r_inflight_layer;
    logic                r_inflight_last;
    logic                r_done;

    kp_t                 w_head;
    kp_t                 w_push_data;
    logic [FIFO_CNT_W-1:0] w_occ;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic [PEND_W-1:0]   w_pending;
    logic                w_room;
    logic                w_final_1;
    logic                w_final_2;
    logic                w_issue_1;
    logic                w_issue_2;
    logic                w_issue_last;
    logic                w_clear;
    logic                w_done_set;

    // Room check: tokens held plus the read in flight, less the one leaving now.
    assign w_pop     = ~w_empty & kp_ready;
    assign w_pending = {1'b0, w_occ} + PEND_W'(r_inflight);
    assign w_room    = ~(w_full & ~w_pop) &
                       (w_pending < PEND_W'(FIFO_DEPTH) + PEND_W'(w_pop));
    assign w_final_1 = ({1'b0, r_addr_1} == r_count_1 - CNT_W'(1));
    assign w_final_2 = ({1'b0, r_addr_2} == r_count_2 - CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count_1 != '0)      w_next_state = READ_1;
                    else if (count_2 != '0) w_next_state = READ_2;
                end
            end
            READ_1: begin
                if (w_issue_1 && w_final_1) w_next_state = (r_count_2 != '0) ? READ_2 : DRAIN;
            end
            READ_2: begin
                if (w_issue_2 && w_final_2) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (w_pop && w_head.last) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: read issue, run setup and completion.
    always_comb begin
        w_issue_1    = (r_state == READ_1) && w_room;
        w_issue_2    = (r_state == READ_2) && w_room;
        w_issue_last = (w_issue_1 && w_final_1 && (r_count_2 == '0)) ||
                       (w_issue_2 && w_final_2);
        w_clear      = (r_state == IDLE) && start;
        w_done_set   = (w_clear && (count_1 == '0) && (count_2 == '0)) ||
                       ((r_state == DRAIN) && w_pop && w_head.last);
    end

    // Latched counts and SRAM read addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_1 <= '0;
            r_count_2 <= '0;
            r_addr_1  <= '0;
            r_addr_2  <= '0;
        end else if (w_clear) begin
            r_count_1 <= clamp_count(count_1);
            r_count_2 <= clamp_count(count_2);
            r_addr_1  <= '0;
            r_addr_2  <= '0;
        end else begin
            if (w_issue_1) r_addr_1 <= r_addr_1 + ADDR_W'(1);
            if (w_issue_2) r_addr_2 <= r_addr_2 + ADDR_W'(1);
        end
    end

    // Tag of the read currently inside the SRAM, pushed when its data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight       <= 1'b0;
            r_inflight_layer <= 1'b0;
            r_inflight_last  <= 1'b0;
        end else begin
            r_inflight       <= w_issue_1 | w_issue_2;
            r_inflight_layer <= w_issue_2;
            r_inflight_last  <= w_issue_last;
        end
    end

    // One-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= w_done_set;
    end

    assign w_push_data = make_kp(r_inflight_layer, r_inflight_last,
                                 r_inflight_layer ? keypoint_2_dout : keypoint_1_dout);

    kp_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_occ),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign keypoint_1_addr = r_addr_1;
    assign keypoint_2_addr = r_addr_2;
    assign kp_valid        = ~w_empty;
    assign kp_row          = w_head.row;
    assign kp_col          = w_head.col;
    assign kp_layer        = w_head.layer;
    assign kp_last         = w_head.last;
    assign busy            = (r_state != IDLE);
    assign done            = r_done;

endmodule

// File: tb/tb_keypoint_reader.sv
// Self-checking bench for keypoint_reader: SRAM models, expected token list
// built from the stored words and counts, timing and backpressure checks.
module tb_keypoint_reader;
    import kp_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  count_1;
    logic [CNT_W-1:0]  count_2;
    logic [ADDR_W-1:0] keypoint_1_addr;
    logic [WORD_W-1:0] keypoint_1_dout;
    logic [ADDR_W-1:0] keypoint_2_addr;
    logic [WORD_W-1:0] keypoint_2_dout;
    logic              kp_valid;
    logic              kp_ready;
    logic [ROW_W-1:0]  kp_row;
    logic [COL_W-1:0]  kp_col;
    logic              kp_layer;
    logic              kp_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0] mem1 [KP_MAX];
    logic [WORD_W-1:0] mem2 [KP_MAX];

    keypoint_reader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .count_1         (count_1),
        .count_2         (count_2),
        .keypoint_1_addr (keypoint_1_addr),
        .keypoint_1_dout (keypoint_1_dout),
        .keypoint_2_addr (keypoint_2_addr),
        .keypoint_2_dout (keypoint_2_dout),
        .kp_valid        (kp_valid),
        .kp_ready        (kp_ready),
        .kp_row          (kp_row),
        .kp_col          (kp_col),
        .kp_layer        (kp_layer),
        .kp_last         (kp_last),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM models.
    always @(posedge clk) begin
        keypoint_1_dout <= mem1[keypoint_1_addr];
        keypoint_2_dout <= mem2[keypoint_2_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] wd(input int row, input int col);
        return {ROW_W'(row), COL_W'(col)};
    endfunction

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_valid"}, kp_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_addr1"}, keypoint_1_addr, 0);
        check({tag, "_addr2"}, keypoint_2_addr, 0);
        check({tag, "_token"}, {kp_layer, kp_last, kp_row, kp_col}, 0);
    endtask

    task automatic load_directed();
        mem1[0] = wd(5, 10);
        mem1[1] = wd(5, 20);
        mem1[2] = wd(7, 3);
        mem2[0] = wd(9, 100);
        mem2[1] = wd(9, 639);
    endtask

    task automatic fill_random();
        for (int i = 0; i < KP_MAX; i++) begin
            mem1[i] = WORD_W'($urandom);
            mem2[i] = WORD_W'($urandom);
        end
    endtask

    // One run. mode 0: ready always, 1: ready every third cycle, 2: random ready.
    task automatic run(input int c1, input int c2, input int mode, input bit poke_start);
        logic [20:0] exp_q[$];
        logic [20:0] tok;
        logic [20:0] prev_tok;
        bit          prev_stall;
        int          n1, n2, n, budget, exp_done;
        int          done_cyc, first_valid, last_hs, accepted, max_ex, ex;
        bit          busy0, busy_seen, valid_seen, a1_moved;

        n1 = (c1 > KP_MAX) ? KP_MAX : c1;
        n2 = (c2 > KP_MAX) ? KP_MAX : c2;
        n  = n1 + n2;
        exp_q = {};
        for (int i = 0; i < n1; i++)
            exp_q.push_back({1'b0, (i == n1 - 1) && (n2 == 0), mem1[i]});
        for (int i = 0; i < n2; i++)
            exp_q.push_back({1'b1, (i == n2 - 1), mem2[i]});

        done_cyc = -1; first_valid = -1; last_hs = -1; accepted = 0; max_ex = 0;
        busy0 = 0; busy_seen = 0; valid_seen = 0; a1_moved = 0; prev_stall = 0;
        prev_tok = '0;
        budget = 4 * n + 40;

        @(negedge clk);
        count_1 = CNT_W'(c1);
        count_2 = CNT_W'(c2);
        start   = 1'b1;

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start = poke_start && (n > 0) && (cyc == 2);
            case (mode)
                0:       kp_ready = 1'b1;
                1:       kp_ready = (cyc % 3 == 0);
                default: kp_ready = 1'($urandom_range(0, 1));
            endcase
            tok = {kp_layer, kp_last, kp_row, kp_col};
            if (cyc == 0) busy0 = busy;
            if (busy) busy_seen = 1;
            if (kp_valid) valid_seen = 1;
            if (kp_valid && first_valid < 0) first_valid = cyc;
            if (keypoint_1_addr != '0) a1_moved = 1;
            ex = int'(keypoint_1_addr) + int'(keypoint_2_addr) - accepted;
            if (ex > max_ex) max_ex = ex;
            if (prev_stall) check("stall_hold", {kp_valid, tok}, {1'b1, prev_tok});
            if (kp_valid && kp_ready) begin
                check("token_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("token", tok, exp_q.pop_front());
                accepted++;
                last_hs = cyc;
            end
            prev_stall = kp_valid && !kp_ready;
            prev_tok   = tok;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;

        if (n == 0)         exp_done = 0;
        else if (mode == 0) exp_done = n + 2;
        else                exp_done = last_hs + 1;
        check("done_seen", done_cyc >= 0, 1);
        check("done_cycle", done_cyc, exp_done);
        check("tokens_left", exp_q.size(), 0);
        check("accepted", accepted, n);
        check("issue_ahead", max_ex <= 2, 1);
        if (n > 0) begin
            check("first_valid", first_valid, 2);
            check("busy_cycle0", busy0, 1);
        end else begin
            check("empty_no_valid", valid_seen, 0);
            check("empty_no_busy", busy_seen, 0);
        end
        if (c1 == 0) check("addr1_still", a1_moved, 0);

        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        check("valid_after", kp_valid, 0);
    endtask

    initial begin
        int acc;
        bit saw_done, saw_valid;

        rst_n    = 1'b0;
        start    = 1'b0;
        kp_ready = 1'b0;
        count_1  = '0;
        count_2  = '0;
        fill_random();
        load_directed();

        repeat (3) @(negedge clk);
        check_quiet_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet_outputs("after_reset");

        // Directed 3+2 run, always ready, then with a 1,0,0 ready pattern.
        run(3, 2, 0, 0);
        run(3, 2, 1, 1);
        // Layer 2 only, and an empty run.
        run(0, 1, 0, 0);
        run(0, 0, 0, 0);

        // Mid-run reset after the second token handshake.
        @(negedge clk);
        count_1  = CNT_W'(3);
        count_2  = CNT_W'(2);
        kp_ready = 1'b1;
        start    = 1'b1;
        acc      = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (kp_valid && kp_ready) acc++;
            if (acc == 2) break;
        end
        check("reset_run_two_tokens", acc, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_quiet_outputs("async_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        saw_done = 0;
        saw_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1;
            if (kp_valid) saw_valid = 1;
        end
        check("no_done_after_abort", saw_done, 0);
        check("no_valid_after_abort", saw_valid, 0);
        run(3, 2, 0, 0);

        // Random contents: full SRAM 1, clamped oversize count, random small runs.
        fill_random();
        run(KP_MAX, 0, 0, 0);
        run(4095, 5, 2, 1);
        for (int k = 0; k < 6; k++) begin
            run($urandom_range(0, 20), $urandom_range(0, 20), (k == 3) ? 1 : 2, k[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
